// File: rtl/a2d_sched.sv
// -----------------------------------------------------------------------------
// a2d_sched
// Conversion scheduler for the shared A2D SPI path. A single `nxt` request is
// turned into the two-transaction ADC128S read: the first transaction sends
// the channel command, and its read word is discarded because it holds the
// previous conversion. The second transaction repeats the command and returns
// the result for the selected channel. Channels are visited round-robin, with
// an optional battery-priority request. A per-transaction watchdog aborts a
// stalled sequence so that sensor updates keep flowing.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   nxt        in   start one conversion (ignored while busy)
//   batt_req   in   battery conversion wins at the next acceptance
//   wrt        out  one-clock start pulse to the SPI monarch
//   wt_data    out  SPI command word {2'b00, ch[2:0], 11'h000}
//   done       in   SPI transaction complete pulse
//   rd_data    in   SPI read word, result in [11:0]
//   lft_ld     out  latest left load cell result
//   rght_ld    out  latest right load cell result
//   steer_pot  out  latest steering pot result
//   batt       out  latest battery result
//   upd        out  one-clock pulse: a result register just changed
//   upd_ch     out  index of the last updated channel (0 lft .. 3 batt)
//   busy       out  sequence in progress
//   tmo_err    out  one-clock pulse on watchdog abort
// -----------------------------------------------------------------------------
module a2d_sched #(
   parameter logic [2:0] CH_LFT   = 3'd0,
   parameter logic [2:0] CH_RGHT  = 3'd4,
   parameter logic [2:0] CH_STEER = 3'd5,
   parameter logic [2:0] CH_BATT  = 3'd6,
   parameter int         TIMEOUT  = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        nxt,
   input  logic        batt_req,
   output logic        wrt,
   output logic [15:0] wt_data,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] steer_pot,
   output logic [11:0] batt,
   output logic        upd,
   output logic [1:0]  upd_ch,
   output logic        busy,
   output logic        tmo_err
);

   // Counter must be able to hold the value TIMEOUT itself.
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMD   = 3'd1,
      WAIT1 = 3'd2,
      GAP   = 3'd3,
      READ  = 3'd4,
      WAIT2 = 3'd5
   } state_t;

   state_t             state_reg, state_next;
   logic [1:0]         ptr_reg;     // round-robin pointer
   logic [1:0]         sel_reg;     // channel index of the running sequence
   logic               adv_reg;     // advance ptr when the sequence ends
   logic [CNT_W-1:0]   cnt_reg;     // watchdog count inside a wait state
   logic [15:0]        wt_data_reg;
   logic               wrt_reg, busy_reg, upd_reg, tmo_err_reg;
   logic [1:0]         upd_ch_reg;

   logic               accept;
   logic [1:0]         sel_next;
   logic               in_wait;
   logic               tmo_hit;
   logic               wrt_next, busy_next, upd_next, tmo_next, fin_next;
   logic [11:0]        res_q [4];

   // rd_data[15:12] carries no result bits.
   logic               unused_rd_hi;
   assign unused_rd_hi = &{1'b0, rd_data[15:12]};

   // Map a channel index (0 lft, 1 rght, 2 steer, 3 batt) to the ADC channel.
   function automatic logic [2:0] adc_ch(input logic [1:0] idx);
      logic [2:0] ch;
      case (idx)
         2'd0:    ch = CH_LFT;
         2'd1:    ch = CH_RGHT;
         2'd2:    ch = CH_STEER;
         default: ch = CH_BATT;
      endcase
      return ch;
   endfunction

   assign accept   = (state_reg == IDLE) && nxt;
   assign sel_next = batt_req ? 2'd3 : ptr_reg;
   assign in_wait  = (state_reg == WAIT1) || (state_reg == WAIT2);
   // A done arriving in the same clock as the limit still wins.
   assign tmo_hit  = in_wait && !done && (cnt_reg == CNT_W'(TIMEOUT));

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (nxt) state_next = CMD;
         CMD:   state_next = WAIT1;
         WAIT1: begin
            if (done)         state_next = GAP;
            else if (tmo_hit) state_next = IDLE;
         end
         GAP:   state_next = READ;
         READ:  state_next = WAIT2;
         WAIT2: begin
            if (done)         state_next = IDLE;
            else if (tmo_hit) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic: next values of the registered outputs. Decoding from
   // state_next lets wrt/busy line up with the state they describe.
   // -------------------------------------------------------------------------
   always_comb begin
      wrt_next  = (state_next == CMD) || (state_next == READ);
      busy_next = (state_next != IDLE);
      upd_next  = (state_reg == WAIT2) && done;
      tmo_next  = tmo_hit;
      fin_next  = upd_next || tmo_next;
   end

   // -------------------------------------------------------------------------
   // Sequence bookkeeping and registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg     <= 2'd0;
         sel_reg     <= 2'd0;
         adv_reg     <= 1'b0;
         cnt_reg     <= '0;
         wt_data_reg <= 16'h0000;
         wrt_reg     <= 1'b0;
         busy_reg    <= 1'b0;
         upd_reg     <= 1'b0;
         upd_ch_reg  <= 2'd0;
         tmo_err_reg <= 1'b0;
      end else begin
         wrt_reg     <= wrt_next;
         busy_reg    <= busy_next;
         upd_reg     <= upd_next;
         tmo_err_reg <= tmo_next;

         // Counter restarts whenever a wait state is entered from outside.
         if (in_wait) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end else begin
            cnt_reg <= '0;
         end

         if (accept) begin
            sel_reg     <= sel_next;
            // A priority battery pick leaves ptr alone unless ptr already
            // points at the battery slot, in which case it counts as a normal
            // visit and the pointer wraps.
            adv_reg     <= !batt_req || (ptr_reg == 2'd3);
            wt_data_reg <= {2'b00, adc_ch(sel_next), 11'h000};
         end

         if (upd_next) begin
            upd_ch_reg <= sel_reg;
         end

         if (fin_next && adv_reg) begin
            ptr_reg <= ptr_reg + 2'd1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Per-channel result holding registers
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_res
         logic [11:0] res_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               res_reg <= 12'h000;
            end else if (upd_next && (sel_reg == 2'(gi))) begin
               res_reg <= rd_data[11:0];
            end
         end
         assign res_q[gi] = res_reg;
      end
   endgenerate

   assign lft_ld    = res_q[0];
   assign rght_ld   = res_q[1];
   assign steer_pot = res_q[2];
   assign batt      = res_q[3];

   assign wrt       = wrt_reg;
   assign wt_data   = wt_data_reg;
   assign busy      = busy_reg;
   assign upd       = upd_reg;
   assign upd_ch    = upd_ch_reg;
   assign tmo_err   = tmo_err_reg;

endmodule

// File: tb/tb_a2d_sched.sv
// -----------------------------------------------------------------------------
// tb_a2d_sched
// Directed bench for a2d_sched. Inputs change 1 time unit after the rising
// edge; outputs are checked at the same point, i.e. away from the edge.
// -----------------------------------------------------------------------------
module tb_a2d_sched;

   localparam int TMO = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        nxt = 1'b0;
   logic        batt_req = 1'b0;
   logic        done = 1'b0;
   logic [15:0] rd_data = 16'h0000;
   logic        wrt, upd, busy, tmo_err;
   logic [15:0] wt_data;
   logic [11:0] lft_ld, rght_ld, steer_pot, batt;
   logic [1:0]  upd_ch;

   int n_cmp  = 0;
   int n_fail = 0;
   int wrt_cnt = 0;
   int upd_cnt = 0;

   a2d_sched #(.TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .nxt       (nxt),
      .batt_req  (batt_req),
      .wrt       (wrt),
      .wt_data   (wt_data),
      .done      (done),
      .rd_data   (rd_data),
      .lft_ld    (lft_ld),
      .rght_ld   (rght_ld),
      .steer_pot (steer_pot),
      .batt      (batt),
      .upd       (upd),
      .upd_ch    (upd_ch),
      .busy      (busy),
      .tmo_err   (tmo_err)
   );

   always #5 clk = ~clk;

   // Pulse counters over the whole run.
   always @(negedge clk) begin
      if (wrt) wrt_cnt++;
      if (upd) upd_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] res_of(input logic [1:0] idx);
      case (idx)
         2'd0:    return lft_ld;
         2'd1:    return rght_ld;
         2'd2:    return steer_pot;
         default: return batt;
      endcase
   endfunction

   // One full conversion with a well-behaved SPI model. poke raises nxt
   // inside both wait states to exercise busy rejection.
   task automatic conv(input string tag, input logic br, input logic [15:0] exp_wt,
                       input logic [1:0] exp_ch, input logic [11:0] val, input logic poke);
      nxt = 1'b1; batt_req = br;
      tick();
      nxt = 1'b0; batt_req = 1'b0;
      chk({tag, ".wrt1"}, 32'(wrt), 32'd1);
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".cmd"},  32'(wt_data), 32'(exp_wt));
      tick();
      chk({tag, ".wrt1_len"}, 32'(wrt), 32'd0);
      if (poke) nxt = 1'b1;
      tick();
      nxt = 1'b0;
      tick();
      done = 1'b1; rd_data = 16'hFFFF;      // stale word, must be discarded
      tick();
      done = 1'b0; rd_data = 16'h0000;
      chk({tag, ".gap"}, 32'(wrt), 32'd0);
      tick();
      chk({tag, ".wrt2"}, 32'(wrt), 32'd1);
      chk({tag, ".cmd2"}, 32'(wt_data), 32'(exp_wt));
      tick();
      if (poke) nxt = 1'b1;
      tick();
      nxt = 1'b0;
      done = 1'b1; rd_data = {4'hA, val};
      tick();
      done = 1'b0; rd_data = 16'h0000;
      chk({tag, ".upd"},    32'(upd), 32'd1);
      chk({tag, ".upd_ch"}, 32'(upd_ch), 32'(exp_ch));
      chk({tag, ".idle"},   32'(busy), 32'd0);
      chk({tag, ".result"}, 32'(res_of(exp_ch)), 32'(val));
      $display("conv %s: ch_idx=%0d cmd=%h result=%h", tag, exp_ch, wt_data, res_of(exp_ch));
      tick();
      chk({tag, ".upd_len"}, 32'(upd), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".wrt"},   32'(wrt), 32'd0);
      chk({tag, ".wt"},    32'(wt_data), 32'd0);
      chk({tag, ".busy"},  32'(busy), 32'd0);
      chk({tag, ".upd"},   32'(upd), 32'd0);
      chk({tag, ".updch"}, 32'(upd_ch), 32'd0);
      chk({tag, ".tmo"},   32'(tmo_err), 32'd0);
      chk({tag, ".lft"},   32'(lft_ld), 32'd0);
      chk({tag, ".rght"},  32'(rght_ld), 32'd0);
      chk({tag, ".steer"}, 32'(steer_pot), 32'd0);
      chk({tag, ".batt"},  32'(batt), 32'd0);
   endtask

   initial begin
      int n;
      int upd_snap;

      // Power-on reset
      tick(); tick();
      chk_all_zero("por");
      rst = 1'b0;
      tick();

      // Round-robin: channels 0,4,5,6,0
      conv("rr0", 1'b0, 16'h0000, 2'd0, 12'h300, 1'b0);
      conv("rr1", 1'b0, 16'h2000, 2'd1, 12'h2A0, 1'b0);
      conv("rr2", 1'b0, 16'h2800, 2'd2, 12'h800, 1'b0);
      conv("rr3", 1'b0, 16'h3000, 2'd3, 12'hC00, 1'b0);
      conv("rr4", 1'b0, 16'h0000, 2'd0, 12'h311, 1'b0);
      chk("rr.rght",  32'(rght_ld), 32'h2A0);
      chk("rr.steer", 32'(steer_pot), 32'h800);

      // Priority battery with ptr=1, then ptr must still be 1 (channel 4).
      // nxt is poked during both waits here.
      conv("prio", 1'b1, 16'h3000, 2'd3, 12'hC55, 1'b1);
      conv("after_prio", 1'b0, 16'h2000, 2'd1, 12'h2A5, 1'b1);

      // Stray done in IDLE
      done = 1'b1; rd_data = 16'h0ABC;
      tick();
      done = 1'b0; rd_data = 16'h0000;
      chk("stray.busy", 32'(busy), 32'd0);
      chk("stray.wrt",  32'(wrt), 32'd0);
      chk("stray.upd",  32'(upd), 32'd0);
      tick();
      chk("stray.wrt2", 32'(wrt), 32'd0);
      chk("stray.lft",  32'(lft_ld), 32'h311);

      // Timeout on channel 5 (ptr=2): done withheld after first wrt
      upd_snap = upd_cnt;
      nxt = 1'b1;
      tick();
      nxt = 1'b0;
      chk("tmo.wrt", 32'(wrt), 32'd1);
      chk("tmo.cmd", 32'(wt_data), 32'h2800);
      n = 0;
      while (!tmo_err && n < 2000) begin
         tick();
         n++;
      end
      // WAIT1 entered one clock after the wrt cycle; abort TMO+1 later.
      chk("tmo.latency", 32'(n), 32'd1026);
      chk("tmo.busy",    32'(busy), 32'd0);
      chk("tmo.steer",   32'(steer_pot), 32'h800);
      chk("tmo.no_upd",  32'(upd_cnt), 32'(upd_snap));
      $display("timeout: tmo_err after %0d cycles from wrt", n);
      tick();
      chk("tmo.pulse", 32'(tmo_err), 32'd0);

      // ptr=3 now: priority battery counts as normal, ptr wraps to 0
      conv("prio_p3", 1'b1, 16'h3000, 2'd3, 12'hC77, 1'b0);
      conv("wrap",    1'b0, 16'h0000, 2'd0, 12'h3A3, 1'b0);

      // Reset during WAIT2 of a channel-4 sequence
      nxt = 1'b1;
      tick();
      nxt = 1'b0;
      chk("rstseq.cmd", 32'(wt_data), 32'h2000);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      tick();
      tick();
      chk("rstseq.wait2", 32'(busy), 32'd1);
      rd_data = 16'h0555; done = 1'b1; rst = 1'b1;
      #1;
      chk_all_zero("rst_async");
      tick();
      chk_all_zero("rst_held");
      rst = 1'b0; done = 1'b0; rd_data = 16'h0000;
      tick();
      conv("post_rst", 1'b0, 16'h0000, 2'd0, 12'h123, 1'b0);
      chk("post_rst.rght", 32'(rght_ld), 32'h000);

      // Pulse totals: 11 complete conversions would be wrong; here there are
      // 10 completions, one timeout (1 wrt) and one reset-aborted sequence (2 wrt).
      chk("total.wrt", 32'(wrt_cnt), 32'd23);
      chk("total.upd", 32'(upd_cnt), 32'd10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
